pc_unit: RTL

// Parametrised program-counter unit: registered PC with next-PC selection (sequential, branch,

---
 rtl/pc_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with next-PC selection, stall hold and return-address stack
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int                INC          = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exception,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             pc_valid,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign
);
  localparam int               CW   = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] LOW  = WIDTH'(INC - 1);
  localparam logic [CW:0]      FULL = (CW + 1)'(RAS_DEPTH);
  logic [WIDTH-1:0] pc_q, pc_d, tgt;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [CW-1:0]    top_q, top_d, wr_ptr;
  logic [CW:0]      cnt_q, cnt_d;
  logic             valid_q, ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;
  logic             push, pop, chk, wr_en;
  assign pc_out        = pc_q;
  assign pc_plus_inc   = pc_q + WIDTH'(INC);
  assign pc_valid      = valid_q;
  assign ras_empty     = cnt_q == '0;
  assign ras_full      = cnt_q == FULL;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misalign      = mis_q;
  // Next-PC selection and stack bookkeeping; the first edge after reset only raises pc_valid so RESET_VECTOR is fetched
  always_comb begin
    pc_d   = pc_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    mis_d  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    chk    = 1'b0;
    tgt    = pc_plus_inc;
    wr_en  = 1'b0;
    wr_ptr = top_q;
    if (valid_q && exception) begin
      pc_d  = EXC_VECTOR;
      cnt_d = '0;
    end else if (valid_q && !stall) begin
      pop    = ret && cnt_q != '0;
      push   = jump && call;
      unf_d  = unf_q | (ret && cnt_q == '0);
      chk    = pop || (!ret && (jump || branch_taken));
      tgt    = pop ? ras_q[top_q] : ret ? pc_plus_inc : jump ? jump_target :
               branch_taken ? branch_target : pc_plus_inc;
      mis_d  = chk && |(tgt & LOW);
      pc_d   = chk ? (tgt & ~LOW) : tgt;
      wr_en  = push;
      wr_ptr = pop ? top_q : top_q + 1'b1;
      top_d  = push == pop ? top_q : push ? top_q + 1'b1 : top_q - 1'b1;
      cnt_d  = push == pop ? cnt_q : push ? (cnt_q == FULL ? cnt_q : cnt_q + 1'b1) : cnt_q - 1'b1;
      ovf_d  = ovf_q | (push && !pop && cnt_q == FULL);
    end
  end
  // PC, stack pointers and flags with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mis_q   <= mis_d;
    end
  end
  // Stack storage; a push after a pop in the same cycle lands in the freed top slot
  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_ptr] <= pc_plus_inc;
  end
endmodule
